// File: rtl/timebase_ctrl.sv
// Time-of-day keeper: prescaled second tick, hh:mm:ss cascade with
// coincident carry pulses, and a one-cycle validated load path.
module timebase_ctrl #(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned PW       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load_req,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  output logic       load_ack,
  output logic       load_err,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_wrap
);

  typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic          load_req_q;
  logic          sec_q, sec_d;
  logic          min_q, min_d;
  logic          hour_q, hour_d;
  logic          day_q, day_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          load_rise;
  logic          load_ok;

  assign load_rise = load_req & ~load_req_q;
  assign load_ok   = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);

  // Next-state: mode transitions, prescaler, time cascade and pulse requests
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    sec_d   = 1'b0;
    min_d   = 1'b0;
    hour_d  = 1'b0;
    day_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      STOP: begin
        if (load_rise)  state_d = LOAD;
        else if (run)   state_d = RUN;
      end
      RUN: begin
        // A load request pre-empts the count, so a coincident terminal
        // count is discarded rather than ticked.
        if (load_rise) begin
          state_d = LOAD;
        end else begin
          if (!run) state_d = STOP;
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            sec_d   = 1'b1;
            if (ss_q == 6'd59) begin
              ss_d  = '0;
              min_d = 1'b1;
              if (mm_q == 6'd59) begin
                mm_d   = '0;
                hour_d = 1'b1;
                if (hh_q == 5'd23) begin
                  hh_d  = '0;
                  day_d = 1'b1;
                end else begin
                  hh_d = hh_q + 5'd1;
                end
              end else begin
                mm_d = mm_q + 6'd1;
              end
            end else begin
              ss_d = ss_q + 6'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = run ? RUN : STOP;
        if (load_ok) begin
          hh_d    = load_hh;
          mm_d    = load_mm;
          ss_d    = load_ss;
          presc_d = '0;
          ack_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = STOP;
    endcase
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STOP;
      presc_q    <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      load_req_q <= 1'b0;
      sec_q      <= 1'b0;
      min_q      <= 1'b0;
      hour_q     <= 1'b0;
      day_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      load_req_q <= load_req;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_tick  = sec_q;
  assign min_tick  = min_q;
  assign hour_tick = hour_q;
  assign day_wrap  = day_q;
  assign load_ack  = ack_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: load-vector table, directed corner sequences and
// a randomized phase checked every cycle against a seconds-of-day model.
module tb_timebase_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       load_req = 1'b0;
  logic [4:0] load_hh = '0;
  logic [5:0] load_mm = '0;
  logic [5:0] load_ss = '0;
  logic       load_ack, load_err;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       sec_tick, min_tick, hour_tick, day_wrap;

  int checks = 0;
  int errors = 0;

  timebase_ctrl #(.PRESCALE(P), .PW(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load_req(load_req),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_ack(load_ack), .load_err(load_err),
    .hh(hh), .mm(mm), .ss(ss),
    .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: time as seconds of day ----------------
  localparam int M_STOP = 0, M_RUN = 1, M_LOAD = 2;
  int   m_mode = M_STOP;
  int   m_p = 0;
  int   m_t = 0;
  logic m_lrq = 1'b0;
  logic e_sec = 0, e_min = 0, e_hour = 0, e_day = 0, e_ack = 0, e_err = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = M_STOP; m_p = 0; m_t = 0; m_lrq = 1'b0;
      e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_ack = 0; e_err = 0;
    end else begin
      logic rise;
      rise = load_req && !m_lrq;
      e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_ack = 0; e_err = 0;
      if (m_mode == M_LOAD) begin
        if (load_hh <= 23 && load_mm <= 59 && load_ss <= 59) begin
          m_t = int'(load_hh) * 3600 + int'(load_mm) * 60 + int'(load_ss);
          m_p = 0;
          e_ack = 1;
        end else begin
          e_err = 1;
        end
        m_mode = run ? M_RUN : M_STOP;
      end else if (rise) begin
        m_mode = M_LOAD;
      end else if (m_mode == M_RUN) begin
        if (m_p == P - 1) begin
          m_p = 0;
          m_t = (m_t + 1) % 86400;
          e_sec  = 1;
          e_min  = (m_t % 60) == 0;
          e_hour = (m_t % 3600) == 0;
          e_day  = m_t == 0;
        end else begin
          m_p = m_p + 1;
        end
        if (!run) m_mode = M_STOP;
      end else if (run) begin
        m_mode = M_RUN;
      end
      m_lrq = load_req;
    end
  end

  // Whole-output comparison against the model on every falling edge
  initial forever begin
    @(negedge clk);
    check("model",
          {hh, mm, ss, sec_tick, min_tick, hour_tick, day_wrap, load_ack, load_err},
          {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60),
           e_sec, e_min, e_hour, e_day, e_ack, e_err});
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [4:0] lh; logic [5:0] lm; logic [5:0] ls;
    logic ack; logic err;
    logic [4:0] eh; logic [5:0] em; logic [5:0] es;
  } vec_t;

  vec_t tbl[9];

  task automatic wait_sec(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sec_tick && n < maxc);
  endtask

  initial begin
    int n;
    int acks;
    logic [5:0] ss0;

    tbl[0] = '{5'd1,  6'd2,  6'd3,  1'b1, 1'b0, 5'd1,  6'd2,  6'd3};
    tbl[1] = '{5'd23, 6'd59, 6'd59, 1'b1, 1'b0, 5'd23, 6'd59, 6'd59};
    tbl[2] = '{5'd24, 6'd0,  6'd0,  1'b0, 1'b1, 5'd23, 6'd59, 6'd59};
    tbl[3] = '{5'd0,  6'd60, 6'd0,  1'b0, 1'b1, 5'd23, 6'd59, 6'd59};
    tbl[4] = '{5'd0,  6'd0,  6'd60, 1'b0, 1'b1, 5'd23, 6'd59, 6'd59};
    tbl[5] = '{5'd31, 6'd63, 6'd63, 1'b0, 1'b1, 5'd23, 6'd59, 6'd59};
    tbl[6] = '{5'd0,  6'd0,  6'd0,  1'b1, 1'b0, 5'd0,  6'd0,  6'd0};
    tbl[7] = '{5'd12, 6'd60, 6'd0,  1'b0, 1'b1, 5'd0,  6'd0,  6'd0};
    tbl[8] = '{5'd12, 6'd34, 6'd56, 1'b1, 1'b0, 5'd12, 6'd34, 6'd56};

    #3;
    check("reset_state",
          {load_ack, load_err, hh, mm, ss, sec_tick, min_tick, hour_tick, day_wrap}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load table, paused so time only moves through loads
    for (int i = 0; i < 9; i++) begin
      load_hh = tbl[i].lh; load_mm = tbl[i].lm; load_ss = tbl[i].ls;
      load_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("load_vec%0d", i),
            {load_ack, load_err, hh, mm, ss, sec_tick, min_tick, hour_tick, day_wrap},
            {tbl[i].ack, tbl[i].err, tbl[i].eh, tbl[i].em, tbl[i].es, 4'b0});
      load_req = 1'b0;
      @(negedge clk);
    end

    // Reset release with run high: first second after 1 + PRESCALE edges
    rst_n = 1'b0;
    run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_sec(20, n);
    check("first_sec_latency", n, 5);
    check("first_sec_ss", ss, 1);
    wait_sec(20, n);
    check("sec_period", n, 4);
    check("second_sec_ss", ss, 2);

    // 23:59:58 load, then midnight with all carries coincident
    load_hh = 5'd23; load_mm = 6'd59; load_ss = 6'd58;
    load_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wrap_load_ack", load_ack, 1'b1);
    load_req = 1'b0;
    wait_sec(20, n);
    check("wrap_sec1_latency", n, 4);
    check("wrap_sec1_time", {hh, mm, ss}, {5'd23, 6'd59, 6'd59});
    wait_sec(20, n);
    check("wrap_sec2_latency", n, 4);
    check("wrap_time_zero", {hh, mm, ss}, 17'd0);
    check("wrap_all_ticks", {sec_tick, min_tick, hour_tick, day_wrap}, 4'b1111);
    @(negedge clk);
    check("wrap_ticks_single", {sec_tick, min_tick, hour_tick, day_wrap}, 4'b0000);

    // Pause at prescaler 2: nothing moves, resume ticks 2 RUN edges later
    wait_sec(20, n);
    @(negedge clk);
    run = 1'b0;
    ss0 = ss;
    repeat (10) begin
      @(negedge clk);
      check("pause_frozen", {sec_tick, ss}, {1'b0, ss0});
    end
    run = 1'b1;
    wait_sec(20, n);
    check("resume_latency", n, 3);

    // Load rising at terminal count: tick dropped, load wins
    repeat (3) @(negedge clk);
    load_hh = 5'd5; load_mm = 6'd6; load_ss = 6'd7;
    load_req = 1'b1;
    @(negedge clk);
    check("tc_load_no_tick", sec_tick, 1'b0);
    @(negedge clk);
    check("tc_load_result", {load_ack, sec_tick, hh, mm, ss}, {1'b1, 1'b0, 5'd5, 6'd6, 6'd7});
    load_req = 1'b0;
    wait_sec(20, n);
    check("tc_next_sec_latency", n, 4);
    check("tc_next_sec_ss", ss, 8);

    // Held load_req: exactly one load
    load_hh = 5'd10; load_mm = 6'd0; load_ss = 6'd0;
    load_req = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (load_ack) acks++;
    end
    check("held_req_one_ack", acks, 1);
    load_req = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-count clears everything immediately
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clear",
          {load_ack, load_err, hh, mm, ss, sec_tick, min_tick, hour_tick, day_wrap}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase: loads near midnight, some out of range, run toggling
    run = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) begin
        load_req = ~load_req;
        load_hh = 5'($urandom_range(20, 24));
        load_mm = 6'($urandom_range(57, 60));
        load_ss = 6'($urandom_range(50, 61));
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000000, clk cycles per second tick; legal range 2 and above.
REQ-002 Parameter PW, default 26, prescaler counter width; SHALL satisfy 2^PW >= PRESCALE.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = timekeeping advances, 0 = paused.
REQ-006 load_req  input  1  level; a rising edge requests a time load.
REQ-007 load_hh / load_mm / load_ss  input  5/6/6  binary time to load; sampled in LOAD state.
REQ-008 load_ack  output  1  one-cycle pulse; load accepted.
REQ-009 load_err  output  1  one-cycle pulse; load rejected (out-of-range field).
REQ-010 hh / mm / ss  output  5/6/6  current time, binary, registered.
REQ-011 sec_tick / min_tick / hour_tick / day_wrap  output  1 each  one-cycle registered pulses.

Function
REQ-012 FSM states SHALL be STOP, RUN, LOAD, encoded in a single state register.
REQ-013 STOP->RUN when run=1; RUN->STOP when run=0; both take effect at the next edge.
REQ-014 STOP or RUN -> LOAD at the edge where load_req=1 and its previous registered sample is 0.
REQ-015 LOAD SHALL last exactly one cycle, then exit to RUN if run=1, else to STOP.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 only in RUN, wrap to 0, and hold its value in STOP (pause, not clear).
REQ-017 At the edge where state=RUN and prescaler=PRESCALE-1: ss increments and sec_tick goes to 1 for one cycle (same cycle as the new ss).
REQ-018 ss 59->0 SHALL pulse min_tick and increment mm in the same edge.
REQ-019 mm 59->0 SHALL likewise pulse hour_tick and increment hh.
REQ-020 hh 23->0 SHALL likewise pulse day_wrap.
REQ-021 All cascaded pulses from one second boundary SHALL be coincident; no carry ripples across cycles.
REQ-022 In LOAD, if load_hh<=23, load_mm<=59 and load_ss<=59:
  - hh/mm/ss take the load values at the exit edge;
  - prescaler clears to 0;
  - load_ack=1 the following cycle.
REQ-023 In LOAD with any field out of range: time and prescaler are unchanged and load_err=1 the following cycle; load_ack stays 0.
REQ-024 A load SHALL never generate sec_tick, min_tick, hour_tick or day_wrap.
REQ-025 Rising load_req in the same cycle as a prescaler terminal count: the load wins and that second's tick is dropped.
REQ-026 load_req held high SHALL trigger exactly one load; a new load requires deassertion first.
REQ-027 A rising load_req while in LOAD SHALL be ignored.
REQ-028 run changing while in LOAD affects only the exit state choice (REQ-015).
REQ-029 Counter arithmetic SHALL be unsigned at the declared widths; the wrap values are compared explicitly, never relying on overflow.

Reset
REQ-030 When rst_n=0, regardless of clk:
  - state=STOP, prescaler=0, hh=mm=ss=0;
  - every pulse output and load_ack/load_err = 0;
  - load_req edge-detect register = 0.
REQ-031 A reset asserted mid-LOAD or mid-count SHALL abort the operation without emitting any pulse.
REQ-032 After release, the first transition occurs at the first rising clk edge with rst_n=1.

Verification (PRESCALE=4)
REQ-033 Reset release, run=1 -> STOP at 1 edge, RUN at the next; sec_tick every 4 cycles; ss=1 coincident with the first sec_tick.
REQ-034 Load 23:59:58, run=1 -> load_ack=1 once.
  - 2 seconds later: hh=mm=ss=0.
  - sec_tick, min_tick, hour_tick and day_wrap all high in the same single cycle.
REQ-035 Load 12:60:00 -> load_err=1 once, load_ack=0, time unchanged, no ticks.
REQ-036 run=1, prescaler reaches 2, then run=0 for 10 cycles -> no ticks and ss frozen.
  - run=1 again: sec_tick 2 cycles after RUN re-entry.
REQ-037 load_req rising in the terminal-count cycle -> no sec_tick; loaded value appears; next sec_tick 4 RUN cycles after LOAD exit.
REQ-038 load_req held high 20 cycles -> exactly one load_ack; rst_n pulsed low mid-count -> all outputs 0 immediately.
